// File: rtl/if_prefetch_queue.sv
// ----------------------------------------------------------------------------
// if_prefetch_queue
//   Instruction prefetch queue between a handshaked instruction memory and the
//   IF stage. The queue fetches sequential words into a DEPTH-entry FIFO and
//   presents {inst, pc4} to IF. A redirect flushes the queue and restarts
//   fetch at the target. If a response is still in flight when the redirect
//   arrives, that response is discarded.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   redirect            taken branch/jump: flush and refetch
//   redirect_pc         new fetch address (bits [1:0] ignored)
//   imem_req/imem_addr  fetch request, held until imem_ack
//   imem_ack/imem_data  response strobe and instruction word
//   out_valid           head entry valid
//   out_inst/out_pc4    head instruction (0 when empty) and its address + 4
//   out_ready           IF consumes the head when out_valid is high
// ----------------------------------------------------------------------------
module if_prefetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_data,
   output logic        out_valid,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc4,
   input  logic        out_ready
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {S_RUN, S_WAIT, S_DRAIN} state_t;

   state_t          state;
   logic [31:0]     fetch_pc;
   logic [CW-1:0]   count;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [31:0]     inst_mem [DEPTH];
   logic [31:0]     pc4_mem  [DEPTH];

   logic            push;
   logic            pop;
   logic            room;
   logic [CW-1:0]   count_nxt;
   logic [CW-1:0]   rest;
   logic [PW-1:0]   rd_nxt;
   logic [31:0]     rpc;
   logic [31:0]     addr_inc;

   // Occupancy bookkeeping shared by the fetch FSM and the FIFO.
   always_comb begin
      push      = (state == S_WAIT) && imem_ack && !redirect;
      pop       = out_valid && out_ready;
      count_nxt = CW'(count + CW'(push) - CW'(pop));
      rest      = CW'(count - CW'(pop));
      rd_nxt    = PW'(rd_ptr + PW'(pop));
      room      = count_nxt < CW'(DEPTH);
      rpc       = redirect_pc & 32'hFFFF_FFFC;
      addr_inc  = imem_addr + 32'd4;
   end

   // Fetch FSM and FIFO control, with the registered head outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_RUN;
         fetch_pc  <= RESET_PC;
         count     <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
         out_valid <= 1'b0;
         out_inst  <= '0;
         out_pc4   <= RESET_PC + 32'd4;
      end else begin
         case (state)
            S_RUN: begin
               if (redirect) begin
                  fetch_pc <= rpc;
               end else if (room) begin
                  imem_req  <= 1'b1;
                  imem_addr <= fetch_pc;
                  state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_ack && !redirect) begin
                  fetch_pc <= addr_inc;
                  if (room) begin
                     imem_addr <= addr_inc;
                  end else begin
                     imem_req <= 1'b0;
                     state    <= S_RUN;
                  end
               end else if (imem_ack) begin
                  // Response belongs to the old path; reissue at the target right away.
                  imem_addr <= rpc;
                  fetch_pc  <= rpc;
               end else if (redirect) begin
                  // Handshake must finish before the new address can be presented.
                  fetch_pc <= rpc;
                  state    <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (redirect) fetch_pc <= rpc;
               if (imem_ack) begin
                  // Stale response dropped; a same-cycle redirect supplies the newest target.
                  imem_addr <= redirect ? rpc : fetch_pc;
                  state     <= S_WAIT;
               end
            end
            default: begin
               state    <= S_RUN;
               imem_req <= 1'b0;
            end
         endcase

         if (redirect) begin
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            out_valid <= 1'b0;
            out_inst  <= '0;
         end else begin
            count     <= count_nxt;
            out_valid <= (count_nxt != '0);
            if (pop)  rd_ptr <= rd_nxt;
            if (push) wr_ptr <= PW'(wr_ptr + PW'(1));
            // Next head: empty, the word being pushed now, or an entry already stored.
            if (count_nxt == '0) begin
               out_inst <= '0;
            end else if (rest == '0) begin
               out_inst <= imem_data;
               out_pc4  <= addr_inc;
            end else begin
               out_inst <= inst_mem[rd_nxt];
               out_pc4  <= pc4_mem[rd_nxt];
            end
         end
      end
   end

   // FIFO storage, written only on accepted responses.
   always_ff @(posedge clk) begin
      if (push) begin
         inst_mem[wr_ptr] <= imem_data;
         pc4_mem[wr_ptr]  <= addr_inc;
      end
   end

endmodule
